cobra_mc_core: RTL and testbench

COBRA_MC_CORE -- requirements
Module: cobra_mc_core

---
 rtl/cobra_pkg.sv | 49 ++++
 rtl/alu_riscv.sv | 30 +++
 rtl/cobra_rf.sv | 27 ++
 rtl/cobra_mc_core.sv | 179 +++++++++++++++++
 tb/tb_cobra_mc_core.sv | 353 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cobra_pkg.sv
// Shared types and encodings for the cobra micro-controller core.
package cobra_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RUN      = 3'd1,
        ST_WAIT_IN  = 3'd2,
        ST_WAIT_OUT = 3'd3,
        ST_HALT     = 3'd4
    } state_e;

    localparam logic [1:0] WS_CONST = 2'd0;
    localparam logic [1:0] WS_ALU   = 2'd1;
    localparam logic [1:0] WS_IN    = 2'd2;
    localparam logic [1:0] WS_OUT   = 2'd3;

    localparam logic [4:0] ALU_ADD  = 5'd0;
    localparam logic [4:0] ALU_SUB  = 5'd1;
    localparam logic [4:0] ALU_AND  = 5'd2;
    localparam logic [4:0] ALU_OR   = 5'd3;
    localparam logic [4:0] ALU_XOR  = 5'd4;
    localparam logic [4:0] ALU_SLL  = 5'd5;
    localparam logic [4:0] ALU_SRL  = 5'd6;
    localparam logic [4:0] ALU_SRA  = 5'd7;
    localparam logic [4:0] ALU_SLT  = 5'd8;
    localparam logic [4:0] ALU_SLTU = 5'd9;

    localparam int unsigned CONST_MSB = 27;
    localparam int unsigned CONST_LSB = 5;
    localparam int unsigned CONST_W   = CONST_MSB - CONST_LSB + 1;

    // Field layout, MSB first: J[31] B[30] WS[29:28] op[27:23] ra1[22:18] ra2[17:13] off[12:5] wa[4:0]
    typedef struct packed {
        logic       j;
        logic       b;
        logic [1:0] ws;
        logic [4:0] op;
        logic [4:0] ra1;
        logic [4:0] ra2;
        logic [7:0] off;
        logic [4:0] wa;
    } instr_t;

    // The constant overlays op..off; sign-extend it to a full word.
    function automatic logic [31:0] sext_const(input logic [31:0] word);
        return {{(32 - CONST_W){word[CONST_MSB]}}, word[CONST_MSB:CONST_LSB]};
    endfunction

endpackage

// File: rtl/alu_riscv.sv
// Team ALU: combinational result plus zero flag.
module alu_riscv
    import cobra_pkg::*;
(
    input  logic [4:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] result_c,
    output logic        flag_c
);

    always_comb begin
        result_c = '0;
        case (op)
            ALU_ADD:  result_c = a + b;
            ALU_SUB:  result_c = a - b;
            ALU_AND:  result_c = a & b;
            ALU_OR:   result_c = a | b;
            ALU_XOR:  result_c = a ^ b;
            ALU_SLL:  result_c = a << b[4:0];
            ALU_SRL:  result_c = a >> b[4:0];
            ALU_SRA:  result_c = 32'($signed(a) >>> b[4:0]);
            ALU_SLT:  result_c = {31'b0, $signed(a) < $signed(b)};
            ALU_SLTU: result_c = {31'b0, a < b};
            default:  result_c = '0;
        endcase
        flag_c = (result_c == '0);
    end

endmodule

// File: rtl/cobra_rf.sv
// Register file: two combinational read ports, one clocked write port, x0 hard-wired to zero.
module cobra_rf #(
    parameter int unsigned NUM_REGS = 32,
    localparam int unsigned AW = $clog2(NUM_REGS)
) (
    input  logic          clk_i,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic [AW-1:0] raddr1,
    input  logic [AW-1:0] raddr2,
    output logic [31:0]   rdata1_c,
    output logic [31:0]   rdata2_c
);

    logic [31:0] regs [NUM_REGS];

    always_ff @(posedge clk_i) begin
        if (we && (waddr != '0)) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata1_c = (raddr1 == '0) ? '0 : regs[raddr1];
    assign rdata2_c = (raddr2 == '0) ? '0 : regs[raddr2];

endmodule

// File: rtl/cobra_mc_core.sv
// Single-cycle stream micro-controller: imem, register file, ALU and in/out stream handshakes.
module cobra_mc_core
    import cobra_pkg::*;
#(
    parameter int unsigned IMEM_DEPTH = 256,
    parameter int unsigned NUM_REGS   = 32,
    parameter logic [31:0] RESET_PC   = 32'h0
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          start_i,
    input  logic                          prog_we_i,
    input  logic [$clog2(IMEM_DEPTH)-1:0] prog_addr_i,
    input  logic [31:0]                   prog_data_i,
    input  logic                          in_valid_i,
    input  logic [31:0]                   in_data_i,
    output logic                          in_ready_o,
    output logic                          out_valid_o,
    output logic [31:0]                   out_data_o,
    input  logic                          out_ready_i,
    output logic                          busy_o,
    output logic                          done_o,
    output logic [31:0]                   pc_o
);

    localparam int unsigned IAW     = $clog2(IMEM_DEPTH);
    localparam int unsigned RAW     = $clog2(NUM_REGS);
    localparam logic [31:0] PC_MASK = 32'(IMEM_DEPTH * 4 - 1);

    logic [31:0] imem [IMEM_DEPTH];

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] out_data_q, out_data_d;
    logic        out_valid_q, out_valid_d;
    logic        busy_q, done_q;

    logic [31:0] instr_word;
    instr_t      instr;
    logic [31:0] rd1, rd2, alu_result, off_ext, pc_next;
    logic        alu_flag, taken, wr_en, is_halt;
    logic        rf_we, imem_we;
    logic [31:0] rf_wdata;

    assign instr_word = imem[pc_q[IAW+1:2]];
    assign instr      = instr_t'(instr_word);

    always_ff @(posedge clk_i) begin
        if (imem_we) begin
            imem[prog_addr_i] <= prog_data_i;
        end
    end

    cobra_rf #(.NUM_REGS(NUM_REGS)) u_rf (
        .clk_i    (clk_i),
        .we       (rf_we),
        .waddr    (instr.wa[RAW-1:0]),
        .wdata    (rf_wdata),
        .raddr1   (instr.ra1[RAW-1:0]),
        .raddr2   (instr.ra2[RAW-1:0]),
        .rdata1_c (rd1),
        .rdata2_c (rd2)
    );

    alu_riscv u_alu (
        .op       (instr.op),
        .a        (rd1),
        .b        (rd2),
        .result_c (alu_result),
        .flag_c   (alu_flag)
    );

    // Branch/jump decode; a stalled IN/OUT recomputes the same target since the RF is unchanged.
    assign off_ext = {{22{instr.off[7]}}, instr.off, 2'b00};
    assign taken   = instr.j ^ (instr.b & alu_flag);
    assign pc_next = (taken ? pc_q + off_ext : pc_q + 32'd4) & PC_MASK;
    assign wr_en   = (instr.j == instr.b);
    assign is_halt = instr.j & ~instr.b & (instr.off == 8'd0);

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        rf_we       = 1'b0;
        rf_wdata    = alu_result;
        imem_we     = 1'b0;
        in_ready_o  = 1'b0;
        case (state_q)
            ST_IDLE, ST_HALT: begin
                imem_we = prog_we_i;
                if (start_i) begin
                    state_d = ST_RUN;
                    pc_d    = RESET_PC;
                end
            end
            ST_RUN: begin
                if (is_halt) begin
                    state_d = ST_HALT;
                end else begin
                    case (instr.ws)
                        WS_CONST: begin
                            rf_we    = wr_en;
                            rf_wdata = sext_const(instr_word);
                            pc_d     = pc_next;
                        end
                        WS_ALU: begin
                            rf_we = wr_en;
                            pc_d  = pc_next;
                        end
                        WS_IN: begin
                            in_ready_o = in_valid_i;
                            if (in_valid_i) begin
                                rf_we    = wr_en;
                                rf_wdata = in_data_i;
                                pc_d     = pc_next;
                            end else begin
                                state_d = ST_WAIT_IN;
                            end
                        end
                        default: begin
                            out_data_d  = rd1;
                            out_valid_d = 1'b1;
                            state_d     = ST_WAIT_OUT;
                        end
                    endcase
                end
            end
            ST_WAIT_IN: begin
                in_ready_o = in_valid_i;
                if (in_valid_i) begin
                    rf_we    = wr_en;
                    rf_wdata = in_data_i;
                    pc_d     = pc_next;
                    state_d  = ST_RUN;
                end
            end
            ST_WAIT_OUT: begin
                if (out_ready_i) begin
                    out_valid_d = 1'b0;
                    pc_d        = pc_next;
                    state_d     = ST_RUN;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Reset aborts any handshake and suppresses all writes in that cycle.
        if (!rst_i) begin
            rf_we      = 1'b0;
            imem_we    = 1'b0;
            in_ready_o = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q     <= ST_IDLE;
            pc_q        <= RESET_PC;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            busy_q      <= (state_d == ST_RUN) || (state_d == ST_WAIT_IN) || (state_d == ST_WAIT_OUT);
            done_q      <= (state_d == ST_HALT);
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign pc_o        = pc_q;

endmodule

// File: tb/tb_cobra_mc_core.sv
// Self-checking bench: cycle-level instruction-set model plus directed programs and random programs.
module tb_cobra_mc_core;
    import cobra_pkg::*;

    localparam int unsigned DEPTH = 16;
    localparam logic [31:0] HALT  = 32'h8000_0000;
    localparam int M_IDLE = 0, M_RUN = 1, M_WIN = 2, M_WOUT = 3, M_HALT = 4;

    logic        clk = 1'b0;
    logic        rst, start, prog_we, in_valid, in_ready, out_valid, out_ready, busy, done;
    logic [3:0]  prog_addr;
    logic [31:0] prog_data, in_data, out_data, pc;

    always #5 clk = ~clk;

    cobra_mc_core #(.IMEM_DEPTH(DEPTH), .NUM_REGS(32), .RESET_PC(32'h0)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .start_i     (start),
        .prog_we_i   (prog_we),
        .prog_addr_i (prog_addr),
        .prog_data_i (prog_data),
        .in_valid_i  (in_valid),
        .in_data_i   (in_data),
        .in_ready_o  (in_ready),
        .out_valid_o (out_valid),
        .out_data_o  (out_data),
        .out_ready_i (out_ready),
        .busy_o      (busy),
        .done_o      (done),
        .pc_o        (pc)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int n_in_xfers = 0;
    bit chk_en = 0;
    logic [31:0] beats[$];
    logic [31:0] prog[DEPTH];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int          m_mode = M_IDLE;
    logic [31:0] m_pc = 0, m_od = 0;
    logic        m_ov = 0;
    logic [31:0] m_mem[DEPTH];
    logic [31:0] m_rf[32];

    function automatic logic [31:0] ref_alu(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            ALU_ADD:  return a + b;
            ALU_SUB:  return a - b;
            ALU_AND:  return a & b;
            ALU_OR:   return a | b;
            ALU_XOR:  return a ^ b;
            ALU_SLL:  return a << b[4:0];
            ALU_SRL:  return a >> b[4:0];
            ALU_SRA:  return 32'($signed(a) >>> b[4:0]);
            ALU_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            ALU_SLTU: return (a < b) ? 32'd1 : 32'd0;
            default:  return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] ref_next_pc(input logic [31:0] cur, input logic [31:0] ins,
                                                input logic [31:0] a, input logic [31:0] b);
        logic        flag, tk;
        logic [31:0] off;
        flag = (ref_alu(ins[27:23], a, b) == 32'd0);
        tk   = ins[31] ^ (ins[30] & flag);
        off  = {{24{ins[12]}}, ins[12:5]};
        return (tk ? cur + (off << 2) : cur + 32'd4) & 32'(DEPTH * 4 - 1);
    endfunction

    function automatic bit ref_halt(input logic [31:0] ins);
        return ins[31] && !ins[30] && (ins[12:5] == 8'd0);
    endfunction

    task automatic ref_write(input logic [31:0] ins, input logic [31:0] v);
        if ((ins[31] == ins[30]) && (ins[4:0] != 5'd0)) m_rf[ins[4:0]] = v;
    endtask

    always @(posedge clk) begin : model
        logic [31:0] ins, a, b, npc;
        ins = m_mem[m_pc[5:2]];
        a   = m_rf[ins[22:18]];
        b   = m_rf[ins[17:13]];
        npc = ref_next_pc(m_pc, ins, a, b);
        if (!rst) begin
            m_mode = M_IDLE; m_pc = 0; m_ov = 0; m_od = 0;
        end else begin
            case (m_mode)
                M_IDLE, M_HALT: begin
                    if (prog_we) m_mem[prog_addr] = prog_data;
                    if (start) begin m_mode = M_RUN; m_pc = 0; end
                end
                M_RUN: begin
                    if (ref_halt(ins)) m_mode = M_HALT;
                    else if (ins[29:28] == 2'd0) begin ref_write(ins, {{9{ins[27]}}, ins[27:5]}); m_pc = npc; end
                    else if (ins[29:28] == 2'd1) begin ref_write(ins, ref_alu(ins[27:23], a, b)); m_pc = npc; end
                    else if (ins[29:28] == 2'd2) begin
                        if (in_valid) begin ref_write(ins, in_data); m_pc = npc; end
                        else m_mode = M_WIN;
                    end else begin
                        m_od = a; m_ov = 1; m_mode = M_WOUT;
                    end
                end
                M_WIN: if (in_valid) begin ref_write(ins, in_data); m_pc = npc; m_mode = M_RUN; end
                M_WOUT: if (out_ready) begin m_ov = 0; m_pc = npc; m_mode = M_RUN; end
                default: m_mode = M_IDLE;
            endcase
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin : compare
        logic [31:0] ins;
        logic        exp_rdy;
        if (chk_en) begin
            ins     = m_mem[m_pc[5:2]];
            exp_rdy = rst && in_valid &&
                      ((m_mode == M_WIN) || (m_mode == M_RUN && !ref_halt(ins) && ins[29:28] == 2'd2));
            check("pc", pc, m_pc);
            check("busy", busy, (m_mode == M_RUN || m_mode == M_WIN || m_mode == M_WOUT));
            check("done", done, (m_mode == M_HALT));
            check("out_valid", out_valid, m_ov);
            check("out_data", out_data, m_od);
            check("in_ready", in_ready, exp_rdy);
            if (rst && out_valid && out_ready) beats.push_back(out_data);
            if (in_ready && in_valid) n_in_xfers++;
        end
    end

    // ---------------- stimulus helpers ----------------
    function automatic logic [31:0] i_const(input int wa, input logic [22:0] c);
        return {4'b0000, c, 5'(wa)};
    endfunction
    function automatic logic [31:0] i_alu(input logic [4:0] op, input int wa, input int ra1, input int ra2,
                                          input bit j, input bit b, input int off);
        return {j, b, 2'b01, op, 5'(ra1), 5'(ra2), 8'(off), 5'(wa)};
    endfunction
    function automatic logic [31:0] i_in(input int wa);
        return {4'b0010, 23'd0, 5'(wa)};
    endfunction
    function automatic logic [31:0] i_out(input int ra);
        return {4'b0011, 5'd0, 5'(ra), 18'd0};
    endfunction
    function automatic logic [31:0] i_jump(input int off);
        return {4'b1000, 15'd0, 8'(off), 5'd0};
    endfunction
    function automatic logic [31:0] beat(input int i);
        if (i < beats.size()) return beats[i];
        return 32'hxxxx_xxxx;
    endfunction

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_prog();
        for (int i = 0; i < DEPTH; i++) prog[i] = HALT;
    endtask

    task automatic load();
        for (int i = 0; i < DEPTH; i++) begin
            prog_we = 1; prog_addr = 4'(i); prog_data = prog[i];
            tick();
        end
        prog_we = 0;
    endtask

    task automatic wait_done(input int max_cyc, input bit rnd);
        int n;
        n = 0;
        while (done !== 1'b1 && n < max_cyc) begin
            if (rnd) begin
                out_ready = 1'($urandom_range(0, 1));
                in_valid  = 1'($urandom_range(0, 1));
                in_data   = $urandom;
            end
            tick();
            n++;
        end
        check("halt_reached", done, 1);
        out_ready = 1; in_valid = 0;
    endtask

    task automatic run_prog(input int max_cyc, input bit rnd);
        start = 1; tick(); start = 0;
        wait_done(max_cyc, rnd);
    endtask

    task automatic set_prog_sum();
        clear_prog();
        prog[0] = i_const(1, 23'd5);
        prog[1] = i_const(2, 23'd7);
        prog[2] = i_alu(ALU_ADD, 3, 1, 2, 0, 0, 0);
        prog[3] = i_out(3);
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 32; i++) m_rf[i] = 0;
        for (int i = 0; i < DEPTH; i++) m_mem[i] = 0;
        rst = 0; start = 0; prog_we = 0; prog_addr = 0; prog_data = 0;
        in_valid = 0; in_data = 0; out_ready = 1;
        tick(); tick();
        chk_en = 1;
        check("rst_pc", pc, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        rst = 1;
        tick();

        // give every register a known value
        for (int base = 1; base < 32; base += 15) begin
            clear_prog();
            for (int k = 0; k < 15 && base + k < 32; k++) prog[k] = i_const(base + k, 23'($urandom));
            load();
            run_prog(40, 0);
        end

        // 5 + 7 = 12
        set_prog_sum(); load(); beats.delete();
        run_prog(30, 0);
        check("sum_beats", beats.size(), 1);
        check("sum_value", beat(0), 32'd12);
        check("sum_pc", pc, 32'd16);

        // IN stall for 10 cycles, then accept 0xDEADBEEF
        begin
            int x0;
            clear_prog(); prog[0] = i_in(4); prog[1] = i_out(4); load();
            beats.delete(); x0 = n_in_xfers;
            in_valid = 0; start = 1; tick(); start = 0;
            repeat (10) tick();
            check("in_stall_pc", pc, 0);
            check("in_stall_busy", busy, 1);
            in_valid = 1; in_data = 32'hDEAD_BEEF; tick(); in_valid = 0;
            wait_done(20, 0);
            check("in_pulses", 32'(n_in_xfers - x0), 1);
            check("in_value", beat(0), 32'hDEAD_BEEF);
        end

        // OUT backpressure with a prog write attempted while running
        set_prog_sum(); load(); beats.delete();
        out_ready = 0; start = 1; tick(); start = 0;
        prog_we = 1; prog_addr = 0; prog_data = 32'hFFFF_FFFF;
        repeat (9) tick();
        prog_we = 0;
        check("outwait_valid", out_valid, 1);
        check("outwait_data", out_data, 32'd12);
        check("outwait_pc", pc, 32'd12);
        out_ready = 1;
        wait_done(20, 0);
        check("outwait_beats", beats.size(), 1);
        beats.delete();
        run_prog(30, 0);
        check("imem_unchanged", beat(0), 32'd12);

        // countdown loop with a -2 branch, random backpressure
        clear_prog();
        prog[0] = i_const(1, 23'd3);
        prog[1] = i_const(2, 23'd1);
        prog[2] = i_out(1);
        prog[3] = i_alu(ALU_SUB, 1, 1, 2, 1, 1, -2);
        load(); beats.delete();
        run_prog(200, 1);
        check("cd_beats", beats.size(), 3);
        check("cd_0", beat(0), 32'd3);
        check("cd_1", beat(1), 32'd2);
        check("cd_2", beat(2), 32'd1);

        // wrap from word 15 back to word 0
        clear_prog(); prog[0] = i_const(12, 23'd1); prog[1] = i_const(13, 23'd2); load();
        run_prog(20, 0);
        clear_prog();
        prog[0]  = i_alu(ALU_SUB, 13, 13, 12, 1, 1, 2);
        prog[2]  = i_out(13);
        prog[3]  = i_jump(12);
        prog[15] = i_const(14, 23'd5);
        load(); beats.delete();
        run_prog(40, 0);
        check("wrap_beats", beats.size(), 1);
        check("wrap_value", beat(0), 32'd1);
        check("wrap_pc", pc, 32'd4);

        // negative constant, x0 write discarded
        clear_prog();
        prog[0] = i_const(5, 23'h40_0000);
        prog[1] = i_const(0, 23'h123);
        prog[2] = i_out(5);
        prog[3] = i_out(0);
        load(); beats.delete();
        run_prog(30, 0);
        check("const_sext", beat(0), 32'hFFC0_0000);
        check("x0_zero", beat(1), 32'd0);

        // reset while waiting on OUT
        clear_prog(); prog[0] = i_out(5); load(); beats.delete();
        out_ready = 0; start = 1; tick(); start = 0;
        repeat (3) tick();
        check("rstout_valid_before", out_valid, 1);
        rst = 0; tick(); rst = 1; out_ready = 1;
        check("rstout_valid_after", out_valid, 0);
        check("rstout_busy", busy, 0);
        check("rstout_pc", pc, 0);
        tick();
        check("rstout_no_beat", beats.size(), 0);

        // random programs with random handshakes, starts, writes and resets
        for (int p = 0; p < 6; p++) begin
            for (int k = 0; k < DEPTH; k++) prog[k] = ($urandom_range(0, 5) == 0) ? HALT : $urandom;
            load();
            start = 1; tick(); start = 0;
            for (int c = 0; c < 300; c++) begin
                out_ready = ($urandom_range(0, 3) != 0);
                in_valid  = ($urandom_range(0, 2) == 0);
                in_data   = $urandom;
                prog_we   = ($urandom_range(0, 7) == 0);
                prog_addr = 4'($urandom);
                prog_data = $urandom;
                start     = ($urandom_range(0, 15) == 0);
                rst       = ($urandom_range(0, 63) != 0);
                tick();
            end
            rst = 0; prog_we = 0; start = 0; in_valid = 0; out_ready = 1;
            tick();
            rst = 1;
            tick();
        end

        chk_en = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
